// File: rtl/lb_pkg.sv
// Shared definitions for the loop replay buffer: RISC-V control-flow opcodes,
// controller state encoding and opcode classification helpers.
package lb_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_TRACK   = 3'd0,
    ST_ARM     = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PREFILL = 3'd3,
    ST_REPLAY  = 3'd4
  } lb_state_e;

  function automatic logic is_ctrl_op(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL) || (opc == OPC_JALR);
  endfunction

  // Only a direct branch or jal can close a capturable loop.
  function automatic logic is_loop_op(input logic [6:0] opc);
    return (opc == OPC_BRANCH) || (opc == OPC_JAL);
  endfunction

endpackage

// File: rtl/lb_mem.sv
// Loop body storage: simple dual-port RAM, one write port and one registered
// read port, written so it maps onto block RAM.
module lb_mem #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [XLEN-1:0]          rd_data
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/loop_replay_buffer.sv
// Loop-stream buffer: captures a short backward-branch loop body from fetch and
// replays it to decode with fetch stalled until the loop-exit mispredict.
module loop_replay_buffer
  import lb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fetch_valid,
  input  logic [XLEN-1:0]  fetch_pc,
  input  logic [XLEN-1:0]  fetch_instr,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_pc,
  input  logic [XLEN-1:0]  br_target,
  input  logic             mispredict,
  input  logic             replay_ready,
  output logic             stall_fetch,
  output logic             replay_valid,
  output logic [XLEN-1:0]  replay_instr,
  output logic [XLEN-1:0]  replay_pc,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] iter_count,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] S_TRACK   = ST_TRACK;
  localparam logic [2:0] S_ARM     = ST_ARM;
  localparam logic [2:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [2:0] S_PREFILL = ST_PREFILL;
  localparam logic [2:0] S_REPLAY  = ST_REPLAY;

  logic [2:0]      state;
  logic [XLEN-1:0] loop_start, loop_end;
  logic [AW-1:0]   len, wr_ptr, rd_ptr, rd_next, rd_addr;
  logic [XLEN-1:0] rd_data, br_dist;
  logic            br_hit, cap_state, cap_last, cap_ok, cap_wr, wrap;
  logic [6:0]      opc;

  assign br_dist = br_pc - br_target;
  assign br_hit  = enable && br_valid && (br_target < br_pc) &&
                   ((br_dist >> 2) < XLEN'(DEPTH));

  // ARM is capture with wr_ptr still at 0, so both states share the checks.
  assign opc       = fetch_instr[6:0];
  assign cap_state = (state == S_ARM) || (state == S_CAPTURE);
  assign cap_last  = (wr_ptr == len);
  assign cap_ok    = (fetch_pc == loop_start + (XLEN'(wr_ptr) << 2)) &&
                     (cap_last ? is_loop_op(opc) : !is_ctrl_op(opc));
  assign cap_wr    = cap_state && fetch_valid && enable && !mispredict && cap_ok;

  assign wrap    = (rd_ptr == len);
  assign rd_next = wrap ? '0 : rd_ptr + AW'(1);

  // Read ahead on accept so back-to-back beats need no bubble; otherwise
  // re-read the current entry, which keeps replay_instr stable.
  always_comb begin
    rd_addr = rd_ptr;
    if (state == S_PREFILL) rd_addr = '0;
    else if (state == S_REPLAY && replay_ready) rd_addr = rd_next;
  end

  lb_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .wr_en   (cap_wr),
    .wr_addr (wr_ptr),
    .wr_data (fetch_instr),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign stall_fetch  = (state == S_PREFILL) || (state == S_REPLAY);
  assign busy         = (state != S_TRACK);
  assign replay_instr = replay_valid ? rd_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_TRACK;
      loop_start   <= '0;
      loop_end     <= '0;
      len          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      iter_count   <= '0;
      replay_valid <= 1'b0;
      replay_pc    <= '0;
      flush        <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      flush <= 1'b0;
      case (state)
        S_TRACK: begin
          if (br_hit && !mispredict) begin
            loop_start <= br_target;
            loop_end   <= br_pc;
            len        <= br_dist[AW+1:2];
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            iter_count <= '0;
            state      <= S_ARM;
          end
        end
        S_ARM, S_CAPTURE: begin
          if (mispredict || !enable) begin
            state <= S_TRACK;
          end else if (fetch_valid) begin
            if (!cap_ok) state <= S_TRACK;
            else if (cap_last) state <= S_PREFILL;
            else begin
              wr_ptr <= wr_ptr + AW'(1);
              state  <= S_CAPTURE;
            end
          end
        end
        S_PREFILL, S_REPLAY: begin
          if (mispredict || !enable) begin
            state        <= S_TRACK;
            flush        <= 1'b1;
            replay_valid <= 1'b0;
            if (mispredict) redirect_pc <= loop_end + XLEN'(4);
            else if (state == S_PREFILL) redirect_pc <= loop_start;
            else redirect_pc <= replay_pc;
          end else if (state == S_PREFILL) begin
            state        <= S_REPLAY;
            replay_valid <= 1'b1;
            replay_pc    <= loop_start;
            rd_ptr       <= '0;
          end else if (replay_ready) begin
            rd_ptr    <= rd_next;
            replay_pc <= loop_start + (XLEN'(rd_next) << 2);
            if (wrap && iter_count != '1) iter_count <= iter_count + CNT_W'(1);
          end
        end
        default: state <= S_TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_replay_buffer.sv
// Bench for loop_replay_buffer: branch-qualification table, directed loop
// sequences and randomized capture/replay trials against a beat-index model.
module tb_loop_replay_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int ITER_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, enable, fetch_valid, br_valid, mispredict, replay_ready;
  logic [XLEN-1:0]  fetch_pc, fetch_instr, br_pc, br_target;
  logic             stall_fetch, replay_valid, flush, busy;
  logic [XLEN-1:0]  replay_instr, replay_pc, redirect_pc;
  logic [CNT_W-1:0] iter_count;

  loop_replay_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .br_valid(br_valid), .br_pc(br_pc), .br_target(br_target),
    .mispredict(mispredict), .replay_ready(replay_ready),
    .stall_fetch(stall_fetch), .replay_valid(replay_valid),
    .replay_instr(replay_instr), .replay_pc(replay_pc),
    .flush(flush), .redirect_pc(redirect_pc),
    .iter_count(iter_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] body [DEPTH];
  logic [31:0] cur_start;
  int          cur_n;

  typedef struct {
    string       name;
    logic        en;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        exp_busy;
  } br_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_body(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      body[i] = {r[31:7], 7'b0010011};
    end
    r = $urandom();
    body[n-1] = {r[31:7], ($urandom_range(0, 1) == 0) ? 7'b1100011 : 7'b1101111};
  endtask

  task automatic start_loop(input logic [31:0] start, input int n);
    cur_start = start;
    cur_n     = n;
    br_valid  = 1'b1;
    br_pc     = start + 32'(4 * (n - 1));
    br_target = start;
    tick();
    br_valid = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_stall", stall_fetch, 0);
  endtask

  // bad_kind: 0 none, 1 control op inside body, 2 wrong pc, 3 non-loop op at end
  task automatic capture(input int bad_slot, input int bad_kind, input bit gaps, output bit ok);
    logic [31:0] pc, ins;
    ok = 1'b1;
    for (int i = 0; i < cur_n; i++) begin
      if (gaps) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          fetch_valid = 1'b0;
          tick();
          chk("gap_busy", busy, 1);
        end
      end
      pc  = cur_start + 32'(4 * i);
      ins = body[i];
      if (i == bad_slot) begin
        case (bad_kind)
          1: ins = {ins[31:7], 7'b1100011};
          2: pc  = pc + 32'd4;
          3: ins = {ins[31:7], ($urandom_range(0, 1) == 0) ? 7'b0010011 : 7'b1100111};
          default: ;
        endcase
      end
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      fetch_instr = ins;
      tick();
      fetch_valid = 1'b0;
      if (i == bad_slot && bad_kind != 0) begin
        chk("abort_busy", busy, 0);
        chk("abort_stall", stall_fetch, 0);
        chk("abort_flush", flush, 0);
        ok = 1'b0;
        return;
      end else if (i < cur_n - 1) begin
        chk("cap_busy", busy, 1);
        chk("cap_stall", stall_fetch, 0);
      end else begin
        chk("prefill_stall", stall_fetch, 1);
        chk("prefill_valid", replay_valid, 0);
      end
    end
  endtask

  // Beat model: the k-th accepted beat is body entry k mod n, iterations = k div n.
  task automatic replay(input int cycles, input bit rnd, input logic [31:0] pat, inout int k);
    for (int c = 0; c < cycles; c++) begin
      int idx;
      int it;
      idx = k % cur_n;
      it  = k / cur_n;
      if (it > ITER_MAX) it = ITER_MAX;
      chk("rp_valid", replay_valid, 1);
      chk("rp_pc", replay_pc, cur_start + 32'(4 * idx));
      chk("rp_instr", replay_instr, body[idx]);
      chk("rp_iter", iter_count, 64'(it));
      chk("rp_stall", stall_fetch, 1);
      if (rnd) replay_ready = ($urandom_range(0, 1) == 1);
      else replay_ready = pat[c % 32];
      tick();
      if (replay_ready) k++;
    end
    replay_ready = 1'b0;
  endtask

  task automatic exit_mispredict();
    replay_ready = 1'b0;
    mispredict   = 1'b1;
    tick();
    mispredict = 1'b0;
    chk("mp_flush", flush, 1);
    chk("mp_redirect", redirect_pc, cur_start + 32'(4 * cur_n));
    chk("mp_valid", replay_valid, 0);
    chk("mp_stall", stall_fetch, 0);
    chk("mp_busy", busy, 0);
    tick();
    chk("mp_flush_once", flush, 0);
  endtask

  task automatic exit_disable(input int k);
    replay_ready = 1'b0;
    enable       = 1'b0;
    tick();
    enable = 1'b1;
    chk("en_flush", flush, 1);
    chk("en_redirect", redirect_pc, cur_start + 32'(4 * (k % cur_n)));
    chk("en_valid", replay_valid, 0);
    chk("en_stall", stall_fetch, 0);
    chk("en_busy", busy, 0);
    tick();
    chk("en_flush_once", flush, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stall"}, stall_fetch, 0);
    chk({tag, "_valid"}, replay_valid, 0);
    chk({tag, "_instr"}, replay_instr, 0);
    chk({tag, "_pc"}, replay_pc, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_redirect"}, redirect_pc, 0);
    chk({tag, "_iter"}, iter_count, 0);
  endtask

  task automatic load_directed();
    body[0] = 32'h00100093;
    body[1] = 32'h00208113;
    body[2] = 32'h00310193;
    body[3] = 32'hFE000AE3;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    br_vec_t vecs [8];
    bit ok;
    int k;

    vecs[0] = '{"short_back",    1'b1, 32'h110, 32'h104,      1'b1};
    vecs[1] = '{"too_long_17",   1'b1, 32'h140, 32'h100,      1'b0};
    vecs[2] = '{"max_len_16",    1'b1, 32'h13C, 32'h100,      1'b1};
    vecs[3] = '{"equal_pc",      1'b1, 32'h200, 32'h200,      1'b0};
    vecs[4] = '{"forward",       1'b1, 32'h100, 32'h120,      1'b0};
    vecs[5] = '{"disabled",      1'b0, 32'h110, 32'h104,      1'b0};
    vecs[6] = '{"unsigned_wrap", 1'b1, 32'h10,  32'hFFFFFFF0, 1'b0};
    vecs[7] = '{"two_instr",     1'b1, 32'h104, 32'h100,      1'b1};

    reset = 1'b1; enable = 1'b0; fetch_valid = 1'b0; br_valid = 1'b0;
    mispredict = 1'b0; replay_ready = 1'b0;
    fetch_pc = '0; fetch_instr = '0; br_pc = '0; br_target = '0;
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    tick();

    // Branch qualification table
    foreach (vecs[i]) begin
      enable    = vecs[i].en;
      br_valid  = 1'b1;
      br_pc     = vecs[i].pc;
      br_target = vecs[i].tgt;
      tick();
      br_valid = 1'b0;
      enable   = 1'b1;
      chk({vecs[i].name, "_busy"}, busy, 64'(vecs[i].exp_busy));
      chk({vecs[i].name, "_stall"}, stall_fetch, 0);
      mispredict = 1'b1;
      tick();
      mispredict = 1'b0;
      chk({vecs[i].name, "_drop"}, busy, 0);
      chk({vecs[i].name, "_noflush"}, flush, 0);
    end

    // 4-instruction loop, full-rate replay, mispredict exit
    load_directed();
    start_loop(32'h104, 4);
    capture(-1, 0, 1'b0, ok);
    tick();
    k = 0;
    replay(10, 1'b0, 32'hFFFFFFFF, k);
    exit_mispredict();

    // Backpressure 1,0,0,1 then steady
    start_loop(32'h104, 4);
    capture(-1, 0, 1'b0, ok);
    tick();
    k = 0;
    replay(8, 1'b0, 32'b1111_1001, k);
    exit_mispredict();

    // enable drop while the 0x10C beat is presented
    start_loop(32'h104, 4);
    capture(-1, 0, 1'b0, ok);
    tick();
    k = 0;
    replay(2, 1'b0, 32'hFFFFFFFF, k);
    chk("drop_at_10c", replay_pc, 32'h10C);
    exit_disable(k);

    // Control op inside body aborts capture
    start_loop(32'h104, 4);
    capture(1, 1, 1'b0, ok);
    for (int i = 2; i < 4; i++) begin
      fetch_valid = 1'b1;
      fetch_pc    = 32'h104 + 32'(4 * i);
      fetch_instr = body[i];
      tick();
      fetch_valid = 1'b0;
      chk("inner_stall", stall_fetch, 0);
      chk("inner_valid", replay_valid, 0);
      chk("inner_flush", flush, 0);
    end

    // Async reset mid-CAPTURE clears outputs without a clock edge
    start_loop(32'h104, 4);
    fetch_valid = 1'b1; fetch_pc = 32'h104; fetch_instr = body[0];
    tick();
    fetch_pc = 32'h108; fetch_instr = body[1];
    tick();
    fetch_valid = 1'b0;
    chk("precap_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("rst_cap");
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Saturating iteration count on a 2-instruction loop, then reset mid-REPLAY
    gen_body(2);
    start_loop(32'h2000, 2);
    capture(-1, 0, 1'b0, ok);
    tick();
    k = 0;
    replay(40, 1'b0, 32'hFFFFFFFF, k);
    reset = 1'b1;
    #1;
    chk("rst_rp_valid", replay_valid, 0);
    chk("rst_rp_stall", stall_fetch, 0);
    chk("rst_rp_flush", flush, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_rp_noflush", flush, 0);
    chk("rst_rp_busy", busy, 0);

    // Randomized trials
    for (int t = 0; t < 40; t++) begin
      int n, kind, slot;
      n = $urandom_range(2, DEPTH);
      gen_body(n);
      kind = $urandom_range(0, 5);
      if (kind > 3) kind = 0;
      case (kind)
        1: slot = $urandom_range(0, n - 2);
        2: slot = $urandom_range(0, n - 1);
        3: slot = n - 1;
        default: slot = -1;
      endcase
      start_loop(32'h1000 + 32'($urandom_range(0, 4095) << 2), n);
      capture(slot, kind, 1'b1, ok);
      if (ok) begin
        tick();
        k = 0;
        replay($urandom_range(1, 40), 1'b1, 32'h0, k);
        if ($urandom_range(0, 1) == 0) exit_mispredict();
        else exit_disable(k);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/loop_replay_buffer.md
# loop_replay_buffer

Parametrised loop-stream buffer for the RISC-V fetch path. It detects short backward taken branches and captures the loop body into an internal buffer as fetch streams it. It then replays that body to decode with fetch stalled, until the loop-exit mispredict. It is the next generation of the single-loop capture FSM, with configurable depth, a valid/ready replay handshake, abort on internal control flow, an enable control and iteration statistics.

## Interface
- XLEN, 32: PC/instruction width.
- DEPTH, 16: buffer entries (power of 2, ≥4); the maximum loop length is DEPTH instructions.
- CNT_W, 16: iteration counter width.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- enable  in  1  allow capture/replay; low forces exit to TRACK
- fetch_valid  in  1  fetch presents an instruction this cycle
- fetch_pc  in  XLEN  PC of fetched instruction
- fetch_instr  in  XLEN  fetched instruction
- br_valid  in  1  resolved taken branch/jal report
- br_pc  in  XLEN  PC of taken branch
- br_target  in  XLEN  its target
- mispredict  in  1  loop branch resolved not-taken (loop exit)
- replay_ready  in  1  decode accepts replay beat
- stall_fetch  out  1  block fetch (PREFILL, REPLAY)
- replay_valid  out  1  replay beat valid
- replay_instr  out  XLEN  replayed instruction
- replay_pc  out  XLEN  its PC
- flush  out  1  one-cycle pulse on replay exit
- redirect_pc  out  XLEN  fetch restart PC, valid with flush
- iter_count  out  CNT_W  completed replay iterations of the current loop, saturating
- busy  out  1  state != TRACK

## Operation
- States: TRACK, ARM, CAPTURE, PREFILL, REPLAY.
- TRACK: on br_valid with br_target < br_pc and (br_pc − br_target)/4 + 1 ≤ DEPTH, and enable=1: latch loop_start=br_target, loop_end=br_pc, len=(br_pc−br_target)>>2 (last index); wr_ptr=0; → ARM. Unsigned XLEN compare; equal PCs are ignored.
- ARM: next fetch_valid with fetch_pc==loop_start: write entry 0, wr_ptr=1, → CAPTURE (→ PREFILL directly if len==0). Any other fetch_valid → TRACK.
- CAPTURE: each fetch_valid requires fetch_pc == loop_start + 4·wr_ptr, otherwise → TRACK.
  - Instruction at loop_end must have a BRANCH or JAL opcode, otherwise → TRACK.
  - Instructions before loop_end with BRANCH/JAL/JALR opcode → TRACK (basic-block rule).
  - Write at wr_ptr, increment. After writing loop_end → PREFILL.
- PREFILL: stall_fetch=1; issue memory read of entry 0; → REPLAY next cycle.
- REPLAY: stall_fetch=1; replay_valid=1; replay_pc=loop_start+4·rd_ptr. On valid&&ready, advance rd_ptr, wrapping len→0; each wrap increments iter_count (saturates at all-ones). Holds instr/pc stable while ready=0.
- Exit: mispredict in REPLAY → flush=1, redirect_pc=loop_end+4, → TRACK. enable=0 in REPLAY/PREFILL → flush=1, redirect_pc=replay_pc (current unissued beat), → TRACK. enable=0 in ARM/CAPTURE → TRACK, no flush.
- mispredict in ARM/CAPTURE → TRACK, no flush.
- Priority: reset > mispredict > enable=0 > fetch/branch events.
- iter_count clears on entry to ARM.

## Timing
- Reset values: all outputs 0; state TRACK; pointers 0.
- Buffer read is registered with 1-cycle latency. PREFILL hides it, so the first replay beat is valid in the cycle after PREFILL. Back-to-back beats follow at one per cycle when ready=1 (read-ahead of rd_ptr+1 on accept).
- stall_fetch is combinational from state. replay/flush/redirect outputs are registered.
- flush is exactly one cycle and coincides with replay_valid=0. stall_fetch deasserts in the same cycle.
- The capture write occurs at the clock edge of the accepted fetch. Wrap uses len, not DEPTH.
- Reset mid-REPLAY: immediate return to TRACK with no flush pulse.

## Structure
- Shared package lb_pkg: opcode constants OPC_BRANCH=7'b1100011, OPC_JAL=7'b1101111, OPC_JALR=7'b1100111; state enum typedef; is_ctrl_op function.
- Sub-module lb_mem: DEPTH×XLEN simple dual-port RAM, one write port and one registered read port, BRAM-inferable.
- Controller, pointers, counters and output registers are in loop_replay_buffer.

## Test plan
- 4-instr loop: br_valid pc=0x110, target=0x104; fetch 0x104..0x110 (last is a BRANCH) → PREFILL, then replay 0x104,0x108,0x10C,0x110,0x104… with ready=1; iter_count=1 after the first wrap.
- Exit: mispredict during replay → flush pulse for 1 cycle, redirect_pc=0x114, stall_fetch drops, state TRACK.
- Too long: DEPTH=16, target=pc−64 (17 instrs) → stays TRACK, busy=0.
- Inner branch: BRANCH opcode at the 2nd capture slot → TRACK, no replay, no flush.
- Backpressure: replay_ready toggled 1,0,0,1 → replay_instr/replay_pc held during 0s, no beat lost or duplicated.
- enable dropped mid-REPLAY at beat 0x10C → flush, redirect_pc=0x10C; async reset mid-CAPTURE → all outputs 0 immediately.
